truth_table_checker: RTL and testbench

Response-side companion to the exhaustive input sweep used on the lab combinational circuits. It accepts one (index, observed-outputs) pair per handshake, compares each against a parameterised expected truth table, and accumulates error count, first-failure index and mask, and a final pass/fail verdict. It sits between the DUT outputs and the board LEDs or simulation log, so that a 16-row sweep self-checks in hardware instead of by eye.

---
 rtl/truth_table_checker_pkg.sv | 29 ++
 rtl/truth_table_checker_lookup.sv | 34 +++
 rtl/truth_table_checker.sv | 165 ++++++++++++++++
 tb/tb_truth_table_checker.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_checker_pkg
//
// Purpose : Shared definitions for the truth-table checker and the later
//           experiment checkers that reuse its row lookup.
//           - state_t       : checker FSM encoding (IDLE / RUN / FINISH)
//           - OBS_*         : bit positions of each lab output inside OBS
//           - DEFAULT_*     : default table geometry (4 inputs, 6 outputs)
// Ports   : none (package)
// ---------------------------------------------------------------------------
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int OBS_F1      = 0;
    localparam int OBS_F2      = 1;
    localparam int OBS_DUALITY = 2;
    localparam int OBS_F3      = 3;
    localparam int OBS_NOTF3   = 4;
    localparam int OBS_F4      = 5;

    localparam int DEFAULT_NUM_IN  = 4;
    localparam int DEFAULT_NUM_OUT = 6;

endpackage

// File: rtl/truth_table_checker_lookup.sv
// ---------------------------------------------------------------------------
// expected_row_lookup
//
// Purpose : Purely combinational selector that returns the expected output
//           vector for one input row of a flattened truth table.
//           Bit [i*NUM_OUT+j] of EXPECTED is output j for input row i.
// Ports   :
//   i_idx  [NUM_IN-1:0]  input row index (A is the MSB)
//   o_row  [NUM_OUT-1:0] expected outputs for that row
// ---------------------------------------------------------------------------
module expected_row_lookup
    import truth_table_checker_pkg::*;
#(
    parameter int NUM_IN  = DEFAULT_NUM_IN,
    parameter int NUM_OUT = DEFAULT_NUM_OUT,
    parameter logic [(2**NUM_IN)*NUM_OUT-1:0] EXPECTED = '0
) (
    input  logic [NUM_IN-1:0]  i_idx,
    output logic [NUM_OUT-1:0] o_row
);

    localparam int ROWS = 2**NUM_IN;

    logic [NUM_OUT-1:0] w_table [ROWS];

    // Unpack the flat parameter into one entry per row so the row select is
    // a plain array index of exactly NUM_IN bits.
    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign w_table[r] = EXPECTED[r*NUM_OUT +: NUM_OUT];
    end

    assign o_row = w_table[i_idx];

endmodule

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Purpose : Receives one (index, observed outputs) pair per VALID/READY
//           handshake during an exhaustive sweep, compares each against the
//           EXPECTED truth table and accumulates an error count, the first
//           failing row and its bit mask, an out-of-order flag and a final
//           pass/fail verdict.
// Ports   :
//   i_clk             clock, all state changes on the rising edge
//   i_rst             synchronous active-high reset
//   i_start           one-cycle pulse that begins a sweep (ignored in RUN)
//   i_valid           i_idx / i_obs hold a row
//   i_idx             input row index, A is the MSB
//   i_obs             observed outputs ([0]=F1 .. [5]=F4)
//   o_ready           row accepted this cycle when i_valid is high
//   o_busy            sweep in progress
//   o_done            sweep complete, results stable
//   o_pass            valid with o_done, no errors and no sequence error
//   o_errCount        number of failing rows (0 .. 2**NUM_IN)
//   o_seqErr          sticky, an index arrived out of ascending order
//   o_firstFailIdx    index of the first failing row
//   o_firstFailMask   observed XOR expected for that row
// ---------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int NUM_IN  = DEFAULT_NUM_IN,
    parameter int NUM_OUT = DEFAULT_NUM_OUT,
    parameter logic [(2**NUM_IN)*NUM_OUT-1:0] EXPECTED = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_valid,
    input  logic [NUM_IN-1:0]  i_idx,
    input  logic [NUM_OUT-1:0] i_obs,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [NUM_IN:0]    o_errCount,
    output logic               o_seqErr,
    output logic [NUM_IN-1:0]  o_firstFailIdx,
    output logic [NUM_OUT-1:0] o_firstFailMask
);

    // Row total of the last row in a sweep, and the saturation ceiling of
    // the error count (one error per row at most).
    localparam logic [NUM_IN:0]   LAST_ROW = {1'b0, {NUM_IN{1'b1}}};
    localparam logic [NUM_IN:0]   ERR_MAX  = {1'b1, {NUM_IN{1'b0}}};
    localparam logic [NUM_IN:0]   CNT_ONE  = (NUM_IN+1)'(1);
    localparam logic [NUM_IN-1:0] IDX_ONE  = (NUM_IN)'(1);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic                 r_seqErr;
    logic [NUM_IN-1:0]    r_counter;
    logic [NUM_IN:0]      r_rowCount;
    logic [NUM_IN:0]      r_errCount;
    logic [NUM_IN-1:0]    r_firstIdx;
    logic [NUM_OUT-1:0]   r_firstMask;

    logic [NUM_OUT-1:0]   w_expRow;
    logic [NUM_OUT-1:0]   w_mismatch;
    logic                 w_rowFails;
    logic                 w_transfer;
    logic                 w_lastRow;
    logic [NUM_IN:0]      w_errNext;
    logic                 w_seqErrNext;

    expected_row_lookup #(
        .NUM_IN   (NUM_IN),
        .NUM_OUT  (NUM_OUT),
        .EXPECTED (EXPECTED)
    ) u_lookup (
        .i_idx (i_idx),
        .o_row (w_expRow)
    );

    // The table is addressed by the incoming index, not by the expected-row
    // counter, so a misordered row is still judged on its own contents.
    assign w_mismatch   = i_obs ^ w_expRow;
    assign w_rowFails   = |w_mismatch;
    assign w_transfer   = i_valid & r_ready;
    assign w_lastRow    = (r_rowCount == LAST_ROW);
    assign w_errNext    = (w_rowFails && (r_errCount != ERR_MAX)) ?
                          (r_errCount + CNT_ONE) : r_errCount;
    assign w_seqErrNext = r_seqErr | (i_idx != r_counter);

    // Single FSM block: sequencing, counters, capture registers and the
    // registered handshake/status outputs. On the final transfer the last
    // row's update and the move to FINISH land on the same edge, so PASS is
    // formed from the post-update error count and sequence flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_seqErr    <= 1'b0;
            r_counter   <= '0;
            r_rowCount  <= '0;
            r_errCount  <= '0;
            r_firstIdx  <= '0;
            r_firstMask <= '0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (i_start) begin
                        r_state     <= RUN;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_seqErr    <= 1'b0;
                        r_counter   <= '0;
                        r_rowCount  <= '0;
                        r_errCount  <= '0;
                        r_firstIdx  <= '0;
                        r_firstMask <= '0;
                    end
                end
                RUN: begin
                    if (w_transfer) begin
                        r_counter  <= r_counter + IDX_ONE;
                        r_rowCount <= r_rowCount + CNT_ONE;
                        r_seqErr   <= w_seqErrNext;
                        r_errCount <= w_errNext;
                        if (w_rowFails && (r_errCount == '0)) begin
                            r_firstIdx  <= i_idx;
                            r_firstMask <= w_mismatch;
                        end
                        if (w_lastRow) begin
                            r_state <= FINISH;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errNext == '0) && !w_seqErrNext;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready         = r_ready;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_errCount      = r_errCount;
    assign o_seqErr        = r_seqErr;
    assign o_firstFailIdx  = r_firstIdx;
    assign o_firstFailMask = r_firstMask;

endmodule

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
//
// Purpose : Self-checking bench for truth_table_checker with a golden
//           4-input / 6-output lab table. Directed sweeps come from a table
//           of scenario records; random sweeps are judged by a reference
//           model that recomputes results from the list of accepted rows.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;
    import truth_table_checker_pkg::*;

    localparam int NI   = 4;
    localparam int NO   = 6;
    localparam int ROWS = 16;

    // Golden lab functions evaluated straight from the input literals.
    function automatic logic [NO-1:0] goldenRow(input logic [NI-1:0] idx);
        logic a, b, c, d;
        logic [NO-1:0] r;
        a = idx[3];
        b = idx[2];
        c = idx[1];
        d = idx[0];
        r = '0;
        r[OBS_F1]      = (a & b) | (c & d);
        r[OBS_F2]      = a ^ b ^ c ^ d;
        r[OBS_DUALITY] = (a | b) & (c | d);
        r[OBS_F3]      = (a & ~c) | (b & d);
        r[OBS_NOTF3]   = ~((a & ~c) | (b & d));
        r[OBS_F4]      = (a | ~b) & (c ^ d);
        return r;
    endfunction

    function automatic logic [ROWS*NO-1:0] buildTable();
        logic [ROWS*NO-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++) t[r*NO +: NO] = goldenRow(NI'(r));
        return t;
    endfunction

    localparam logic [ROWS*NO-1:0] GOLDEN = buildTable();

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          valid;
    logic [NI-1:0] idx;
    logic [NO-1:0] obs;
    logic          ready, busy, done, pass, seqErr;
    logic [NI:0]   errCount;
    logic [NI-1:0] firstIdx;
    logic [NO-1:0] firstMask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    truth_table_checker #(
        .NUM_IN   (NI),
        .NUM_OUT  (NO),
        .EXPECTED (GOLDEN)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_valid         (valid),
        .i_idx           (idx),
        .i_obs           (obs),
        .o_ready         (ready),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass          (pass),
        .o_errCount      (errCount),
        .o_seqErr        (seqErr),
        .o_firstFailIdx  (firstIdx),
        .o_firstFailMask (firstMask)
    );

    // Reference model state: rows accepted in the current sweep.
    logic [NI-1:0] mIdx [$];
    logic [NO-1:0] mObs [$];

    function automatic int modelErrCount();
        int n = 0;
        foreach (mIdx[i]) if (mObs[i] != goldenRow(mIdx[i])) n++;
        return n;
    endfunction

    function automatic int modelFirstIdx();
        foreach (mIdx[i]) if (mObs[i] != goldenRow(mIdx[i])) return int'(mIdx[i]);
        return 0;
    endfunction

    function automatic int modelFirstMask();
        foreach (mIdx[i]) if (mObs[i] != goldenRow(mIdx[i])) return int'(mObs[i] ^ goldenRow(mIdx[i]));
        return 0;
    endfunction

    function automatic int modelSeqErr();
        foreach (mIdx[i]) if (int'(mIdx[i]) != (i % ROWS)) return 1;
        return 0;
    endfunction

    function automatic int modelPass();
        return (modelErrCount() == 0 && modelSeqErr() == 0) ? 1 : 0;
    endfunction

    // Sweep description consumed by applyStimulus.
    logic [NI-1:0] sIdx [ROWS];
    logic [NO-1:0] sObs [ROWS];
    int            sGap [ROWS];
    int            sStartRow;

    typedef struct {
        string         name;
        logic [NO-1:0] allMask;
        logic [NI-1:0] rowA;
        logic [NO-1:0] maskA;
        logic [NI-1:0] rowB;
        logic [NO-1:0] maskB;
        bit            swap23;
        int            expErr;
        int            expFirstIdx;
        int            expFirstMask;
        int            expSeqErr;
        int            expPass;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic buildSweep(input logic [NO-1:0] allMask, input logic [NI-1:0] rowA,
                              input logic [NO-1:0] maskA, input logic [NI-1:0] rowB,
                              input logic [NO-1:0] maskB, input bit swap23);
        for (int i = 0; i < ROWS; i++) begin
            logic [NI-1:0] k;
            k = NI'(i);
            if (swap23 && i == 2) k = 4'd3;
            if (swap23 && i == 3) k = 4'd2;
            sIdx[i] = k;
            sObs[i] = goldenRow(k) ^ allMask ^ ((k == rowA) ? maskA : '0) ^ ((k == rowB) ? maskB : '0);
            sGap[i] = 0;
        end
        sStartRow = -1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ready"}, ready, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " pass"}, pass, 0);
        checkOutput({tag, " seqErr"}, seqErr, 0);
        checkOutput({tag, " errCount"}, errCount, 0);
        checkOutput({tag, " firstIdx"}, firstIdx, 0);
        checkOutput({tag, " firstMask"}, firstMask, 0);
    endtask

    // Runs one sweep: START, then the 16 described rows with optional idle
    // gaps (random junk on idx/obs while VALID is low) and an optional START
    // pulse coinciding with one row. DONE must rise exactly after row 15.
    task automatic applyStimulus(input string tag);
        mIdx.delete();
        mObs.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, " ready after start"}, ready, 1);
        checkOutput({tag, " busy after start"}, busy, 1);
        checkOutput({tag, " done after start"}, done, 0);
        for (int i = 0; i < ROWS; i++) begin
            valid = 1'b1;
            idx   = sIdx[i];
            obs   = sObs[i];
            start = (i == sStartRow);
            tick();
            start = 1'b0;
            valid = 1'b0;
            mIdx.push_back(sIdx[i]);
            mObs.push_back(sObs[i]);
            if (i < ROWS - 1) begin
                checkOutput({tag, " done mid-sweep"}, done, 0);
                checkOutput({tag, " errCount running"}, errCount, modelErrCount());
                for (int g = 0; g < sGap[i]; g++) begin
                    idx = NI'($urandom);
                    obs = NO'($urandom);
                    tick();
                end
            end
        end
    endtask

    task automatic checkResults(input string tag);
        int holdErr;
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " ready at done"}, ready, 0);
        checkOutput({tag, " busy at done"}, busy, 0);
        checkOutput({tag, " errCount"}, errCount, modelErrCount());
        checkOutput({tag, " firstIdx"}, firstIdx, modelFirstIdx());
        checkOutput({tag, " firstMask"}, firstMask, modelFirstMask());
        checkOutput({tag, " seqErr"}, seqErr, modelSeqErr());
        checkOutput({tag, " pass"}, pass, modelPass());
        // VALID in FINISH must not disturb the held results.
        holdErr = modelErrCount();
        valid = 1'b1;
        for (int h = 0; h < 2; h++) begin
            idx = NI'($urandom);
            obs = NO'($urandom);
            tick();
        end
        valid = 1'b0;
        checkOutput({tag, " done held"}, done, 1);
        checkOutput({tag, " errCount held"}, errCount, holdErr);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        idx   = '0;
        obs   = '0;

        vecs[0] = '{"allMatch",  6'b000000, 4'd0, 6'b000000, 4'd0,  6'b000000, 1'b0,  0, 0, 6'b000000, 0, 1};
        vecs[1] = '{"singleFault", 6'b000000, 4'd9, 6'b001000, 4'd0, 6'b000000, 1'b0, 1, 9, 6'b001000, 0, 0};
        vecs[2] = '{"multiFault", 6'b000000, 4'd2, 6'b000001, 4'd12, 6'b110000, 1'b0, 2, 2, 6'b000001, 0, 0};
        vecs[3] = '{"outOfOrder", 6'b000000, 4'd0, 6'b000000, 4'd0, 6'b000000, 1'b1,  0, 0, 6'b000000, 1, 0};
        vecs[4] = '{"allFail",   6'b100001, 4'd0, 6'b000000, 4'd0,  6'b000000, 1'b0, 16, 0, 6'b100001, 0, 0};

        tick();
        tick();
        checkResetState("reset");
        rst = 1'b0;

        // VALID while IDLE is not accepted.
        valid = 1'b1;
        idx   = 4'd5;
        obs   = 6'b111111;
        tick();
        tick();
        checkOutput("idle ready", ready, 0);
        checkOutput("idle errCount", errCount, 0);
        valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            buildSweep(vecs[v].allMask, vecs[v].rowA, vecs[v].maskA,
                       vecs[v].rowB, vecs[v].maskB, vecs[v].swap23);
            applyStimulus(vecs[v].name);
            checkOutput({vecs[v].name, " tbl errCount"}, errCount, vecs[v].expErr);
            checkOutput({vecs[v].name, " tbl firstIdx"}, firstIdx, vecs[v].expFirstIdx);
            checkOutput({vecs[v].name, " tbl firstMask"}, firstMask, vecs[v].expFirstMask);
            checkOutput({vecs[v].name, " tbl seqErr"}, seqErr, vecs[v].expSeqErr);
            checkOutput({vecs[v].name, " tbl pass"}, pass, vecs[v].expPass);
            checkResults(vecs[v].name);
        end

        // Gapped VALID after row 5 plus a START pulse alongside row 7.
        buildSweep('0, 4'd0, '0, 4'd0, '0, 1'b0);
        sGap[5]   = 3;
        sStartRow = 7;
        applyStimulus("gapped");
        checkOutput("gapped tbl pass", pass, 1);
        checkOutput("gapped tbl errCount", errCount, 0);
        checkResults("gapped");

        // Reset in the middle of a sweep that already has one error.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            valid = 1'b1;
            idx   = NI'(i);
            obs   = goldenRow(NI'(i)) ^ ((i == 3) ? 6'b000100 : 6'b000000);
            tick();
        end
        valid = 1'b0;
        checkOutput("midReset errCount before", errCount, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState("midReset");
        buildSweep('0, 4'd0, '0, 4'd0, '0, 1'b0);
        applyStimulus("afterReset");
        checkOutput("afterReset tbl pass", pass, 1);
        checkResults("afterReset");

        // Random sweeps judged by the model.
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < ROWS; i++) begin
                sIdx[i] = ($urandom_range(7) == 0) ? NI'($urandom_range(15)) : NI'(i);
                sObs[i] = goldenRow(sIdx[i]) ^
                          (($urandom_range(3) == 0) ? NO'($urandom_range(63, 1)) : NO'(0));
                sGap[i] = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            end
            sStartRow = ($urandom_range(4) == 0) ? int'($urandom_range(15)) : -1;
            applyStimulus("random");
            checkResults("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
